// File: rtl/rr_arbiter4_if.sv
// Bundle between the four requesters and the round-robin arbiter that owns the
// shared 4:1 data mux.
interface rr_arbiter4_if #(
  parameter int DW = 4
);
  logic [3:0]    req;
  logic [DW-1:0] din0;
  logic [DW-1:0] din1;
  logic [DW-1:0] din2;
  logic [DW-1:0] din3;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          busy;

  modport master (
    output req, din0, din1, din2, din3,
    input  gnt, sel, dout, dout_vld, busy
  );

  modport slave (
    input  req, din0, din1, din2, din3,
    output gnt, sel, dout, dout_vld, busy
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a hold cap under contention; it drives
// the select lines and output of the shared 4:1 data mux.
module rr_arbiter4 #(
  parameter int DW       = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [1:0]    ptr_r, ptr_s;
  logic [HW-1:0] hold_r, hold_s;
  logic [3:0]    gnt_r, gnt_s;
  logic [1:0]    sel_r, sel_s;
  logic          busy_r, busy_s;
  logic [3:0]    others_s;
  logic [1:0]    win_s;
  logic [DW-1:0] dout_s;

  // First requester after pointer p, scanning p+1, p+2, p+3, p (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = p;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  function automatic logic [3:0] to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 2'd3;
      hold_r  <= '0;
      gnt_r   <= 4'b0000;
      sel_r   <= 2'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      hold_r  <= hold_s;
      gnt_r   <= gnt_s;
      sel_r   <= sel_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state: grant, release, hand-over without a bubble, or forced rotation.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    hold_s   = hold_r;
    gnt_s    = gnt_r;
    sel_s    = sel_r;
    others_s = bus.req & ~to_onehot(sel_r);
    win_s    = 2'd0;
    case (state_r)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          win_s   = rr_pick(bus.req, ptr_r);
          gnt_s   = to_onehot(win_s);
          sel_s   = win_s;
          ptr_s   = win_s;
          hold_s  = '0;
          state_s = GRANT;
        end else begin
          gnt_s   = 4'b0000;
          state_s = IDLE;
        end
      end
      GRANT: begin
        // Hand-over (release or hold cap) arbitrates over the others only.
        if (others_s != 4'b0000 && (!bus.req[sel_r] || hold_r == HOLD_LAST)) begin
          win_s   = rr_pick(others_s, ptr_r);
          gnt_s   = to_onehot(win_s);
          sel_s   = win_s;
          ptr_s   = win_s;
          hold_s  = '0;
          state_s = GRANT;
        end else if (!bus.req[sel_r]) begin
          gnt_s   = 4'b0000;
          hold_s  = '0;
          state_s = IDLE;
        end else if (hold_r != HOLD_LAST) begin
          hold_s  = hold_r + HW'(1);
        end else begin
          hold_s  = hold_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
        hold_s  = '0;
      end
    endcase
    busy_s = (gnt_s != 4'b0000);
  end

  // Shared data mux driven from the registered select.
  always_comb begin
    dout_s = '0;
    if (gnt_r != 4'b0000) begin
      case (sel_r)
        2'd0:    dout_s = bus.din0;
        2'd1:    dout_s = bus.din1;
        2'd2:    dout_s = bus.din2;
        2'd3:    dout_s = bus.din3;
        default: dout_s = '0;
      endcase
    end else begin
      dout_s = '0;
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.sel      = sel_r;
  assign bus.busy     = busy_r;
  assign bus.dout     = dout_s;
  assign bus.dout_vld = |(gnt_r & bus.req);

endmodule
